// File: rtl/ws2812_driver.sv
// WS2812/SK6812 serial LED chain driver: per-LED colour memory, bit-cell encoder and latch gap.
// Optional macro WS2812_BRIGHTNESS_EN adds an 8-bit brightness input applied to each colour byte at load.
`timescale 1ns/1ps
module ws2812_driver #(
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24,
    parameter int T0H          = 4,
    parameter int T1H          = 10,
    parameter int T_PERIOD     = 15,
    parameter int T_RESET      = 800,
    parameter int AUTO_REFRESH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]              brightness,
`endif
    input  logic [BITS_PER_LED-1:0] rgb_data,
    input  logic [7:0]              led_num,
    input  logic                    write,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    data
);

    localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CYC_W = $clog2(T_PERIOD);
    localparam int CNT_W = $clog2(T_RESET + 1);
    localparam int BIT_W = $clog2(BITS_PER_LED);

    typedef enum logic [1:0] {IDLE, DATA, LATCH} state_t;

    state_t                  state_q, state_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [LED_W-1:0]        led_q, led_d, led_next;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BITS_PER_LED-1:0] shift_q, shift_d, load_w;
    logic                    data_q, data_d;
    logic                    frame_done_q, frame_done_d;
    logic                    busy_q, busy_d;
    logic                    pending_q, pending_d;
    logic                    start_ok, load;
    logic [BITS_PER_LED-1:0] mem_q [NUM_LEDS];

    function automatic logic cell_level(input logic b, input logic [CYC_W-1:0] pos);
        return pos < (b ? CYC_W'(T1H) : CYC_W'(T0H));
    endfunction

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [BITS_PER_LED-1:0] scale_word(input logic [BITS_PER_LED-1:0] w,
                                                           input logic [7:0] b);
        logic [BITS_PER_LED-1:0] r;
        logic [15:0]             prod;
        r = '0;
        for (int i = 0; i < BITS_PER_LED / 8; i++) begin
            prod = {8'd0, w[i*8 +: 8]} * ({8'd0, b} + 16'd1);
            r[i*8 +: 8] = prod[15:8];
        end
        return r;
    endfunction

    assign load_w = scale_word(mem_q[led_next], brightness);
`else
    assign load_w = mem_q[led_next];
`endif

    // Index of the word loaded at the next cell start: the following LED mid-frame, LED 0 otherwise.
    assign led_next = (state_q == DATA) ? led_q + LED_W'(1) : '0;
    assign start_ok = (AUTO_REFRESH != 0) ? 1'b0 : start;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        led_d        = led_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        pending_d    = pending_q;
        data_d       = 1'b0;
        frame_done_d = 1'b0;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) load = 1'b1;
            end
            DATA: begin
                if (start_ok) pending_d = 1'b1;
                if (cyc_q != CYC_W'(T_PERIOD - 1)) begin
                    cyc_d  = cyc_q + CYC_W'(1);
                    data_d = cell_level(shift_q[BITS_PER_LED-1], cyc_q + CYC_W'(1));
                end else if (bit_q != BIT_W'(BITS_PER_LED - 1)) begin
                    cyc_d   = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    shift_d = shift_q << 1;
                    data_d  = 1'b1;
                end else if (led_q != LED_W'(NUM_LEDS - 1)) begin
                    load = 1'b1;
                end else begin
                    cyc_d        = '0;
                    state_d      = LATCH;
                    cnt_d        = CNT_W'(T_RESET);
                    frame_done_d = (T_RESET == 1);
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(1)) begin
                    // A start landing on the final gap cycle is honoured directly.
                    if ((AUTO_REFRESH != 0) || pending_q || start_ok) begin
                        load      = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d        = cnt_q - CNT_W'(1);
                    frame_done_d = (cnt_q == CNT_W'(2));
                    if (start_ok) pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = DATA;
            led_d   = led_next;
            bit_d   = '0;
            cyc_d   = '0;
            shift_d = load_w;
            data_d  = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LATCH;
            cnt_q        <= CNT_W'(T_RESET);
            cyc_q        <= '0;
            bit_q        <= '0;
            led_q        <= '0;
            data_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b1;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cyc_q        <= cyc_d;
            bit_q        <= bit_d;
            led_q        <= led_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) mem_q[i] <= '0;
        end else if (write && ({1'b0, led_num} < 9'(NUM_LEDS))) begin
            mem_q[led_num[LED_W-1:0]] <= rgb_data;
        end
    end

    assign data       = data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver: randomized writes against a timeline model, serial-line decoder as monitor.
// A second small instance with AUTO_REFRESH=0 covers start, pending and return to IDLE.
`timescale 1ns/1ps
module tb_ws2812_driver;
    localparam int NL        = 8;
    localparam int BPL       = 24;
    localparam int T0        = 4;
    localparam int T1        = 10;
    localparam int TP        = 15;
    localparam int TR        = 800;
    localparam int WORD_CYC  = BPL * TP;
    localparam int FRAME_CYC = NL * WORD_CYC + TR;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [BPL-1:0] rgb_data = '0;
    logic [7:0]     led_num = '0;
    logic           write = 1'b0;
    logic           start = 1'b0;
    logic           busy, frame_done, data;
    logic           start_b = 1'b0;
    logic           write_b = 1'b0;
    logic           busy_b, frame_done_b, data_b;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]     brightness = 8'h7F;
`endif

    always #5 clk = ~clk;

    ws2812_driver #(.NUM_LEDS(NL), .BITS_PER_LED(BPL), .T0H(T0), .T1H(T1), .T_PERIOD(TP),
                    .T_RESET(TR), .AUTO_REFRESH(1)) dut (
        .clk(clk), .reset(reset),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .rgb_data(rgb_data), .led_num(led_num), .write(write), .start(start),
        .busy(busy), .frame_done(frame_done), .data(data));

    ws2812_driver #(.NUM_LEDS(2), .BITS_PER_LED(BPL), .T0H(T0), .T1H(T1), .T_PERIOD(TP),
                    .T_RESET(20), .AUTO_REFRESH(0)) dut_b (
        .clk(clk), .reset(reset),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .rgb_data(rgb_data), .led_num(led_num), .write(write_b), .start(start_b),
        .busy(busy_b), .frame_done(frame_done_b), .data(data_b));

    int             vectors = 0;
    int             miscompares = 0;
    logic [BPL-1:0] exp_q[$];
    logic [BPL-1:0] model_mem [NL];
    bit             rel = 1'b0;
    bit             b_done = 1'b0;
    int             hi = 0, lo = 0, gap = 0, nbits = 0;
    logic [BPL-1:0] word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BPL-1:0] model_word(input logic [BPL-1:0] w);
        logic [BPL-1:0] r;
        r = w;
`ifdef WS2812_BRIGHTNESS_EN
        for (int i = 0; i < BPL / 8; i++)
            r[i*8 +: 8] = 8'((int'(w[i*8 +: 8]) * (int'(brightness) + 1)) / 256);
`endif
        return r;
    endfunction

    // Clock edge k counts from reset release; LED i of frame f is loaded at edge
    // TR + f*FRAME_CYC + i*WORD_CYC and sees every write made at an earlier edge.
    task automatic run_phase(input int frames, input bit writes);
        int ncyc;
        int pos;
        ncyc = TR + frames * FRAME_CYC;
        for (int i = 0; i < NL; i++) model_mem[i] = '0;
        for (int k = 1; k < ncyc; k++) begin
            if (k >= TR) begin
                pos = (k - TR) % FRAME_CYC;
                if (pos < NL * WORD_CYC && pos % WORD_CYC == 0)
                    exp_q.push_back(model_word(model_mem[pos / WORD_CYC]));
            end
            write    = writes && ($urandom_range(0, 47) == 0);
            led_num  = 8'($urandom_range(0, 9));
            rgb_data = BPL'($urandom);
            if (write && led_num < NL) model_mem[led_num] = rgb_data;
            @(posedge clk);
            #1;
        end
        write = 1'b0;
    endtask

    task automatic finish_cell();
        vectors++;
        if (!(hi == T0 || hi == T1) || hi + lo != TP) begin
            miscompares++;
            $display("FAIL cell_shape: high %0d total %0d, expected high %0d or %0d total %0d",
                     hi, hi + lo, T0, T1, TP);
        end
        word = {word[BPL-2:0], (hi == T1)};
        nbits++;
        if (nbits == BPL) begin
            nbits = 0;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL led_word: got %0h, expected no word", word);
            end else begin
                check("led_word", word, exp_q.pop_front());
            end
            check("busy_in_frame", busy, 1);
        end
        hi = 0;
        lo = 0;
    endtask

    // Monitor: decode the serial line into words and check gaps and frame_done alignment.
    initial begin
        logic exp_fd;
        forever begin
            @(negedge clk);
            if (reset) begin
                hi = 0; lo = 0; gap = 0; nbits = 0; word = '0;
            end else if (data) begin
                if (hi > 0 && lo > 0) finish_cell();
                if (hi == 0 && gap > 0) begin
                    check("latch_gap", gap, TR);
                    gap = 0;
                end
                hi++;
            end else if (hi > 0) begin
                lo++;
                if (hi + lo == TP) finish_cell();
            end else begin
                gap++;
            end
            exp_fd = !reset && !data && hi == 0 && gap == TR;
            if (exp_fd || frame_done) check("frame_done", frame_done, exp_fd);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data, 0);
        check("reset_busy", busy, 1);
        check("reset_frame_done", frame_done, 0);
        check("reset_busy_b", busy_b, 1);
        reset = 1'b0;
        rel = 1'b1;
        run_phase(3, 1'b1);
        check("queue_drained_1", exp_q.size(), 0);

        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (data) break;
            t++;
        end
        check("next_frame_start", data, 1);
        @(posedge clk);
        #2;
        check("pre_reset_high", data, 1);
        #1 reset = 1'b1;
        #1;
        check("midframe_reset_data", data, 0);
        check("midframe_reset_busy", busy, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_phase(1, 1'b0);
        check("queue_drained_2", exp_q.size(), 0);
        check("b_done", b_done, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int  t, nfd, idle_hi;
        bit  chk_next;
        wait (rel == 1'b1);
        t = 0;
        while (t < 100 && busy_b) begin
            @(negedge clk);
            t++;
        end
        check("b_idle_busy", busy_b, 0);
        check("b_idle_data", data_b, 0);
        @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        @(negedge clk);
        check("b_first_cell", {busy_b, data_b}, 2'b11);
        repeat (100) @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        nfd = 0;
        idle_hi = 0;
        chk_next = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (chk_next) begin
                chk_next = 1'b0;
                if (nfd == 1) check("b_extra_frame_start", data_b, 1);
                else check("b_back_to_idle", {busy_b, data_b}, 2'b00);
            end
            if (frame_done_b) begin
                nfd++;
                chk_next = 1'b1;
            end
            if (!busy_b && data_b) idle_hi++;
        end
        check("b_frame_count", nfd, 2);
        check("b_idle_high", idle_hi, 0);
        check("b_final_busy", busy_b, 0);
        b_done = 1'b1;
    end
endmodule
